sat_bin_loader: RTL



---
 rtl/sat_bin_loader.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/sat_bin_loader.sv
// Host-side loader for sat_bin: parses a 32-bit command/data stream, fills the
// four bin RAMs through the external write ports, then runs the solver once.
module sat_bin_loader #(
  parameter int WIDTH_VAR        = 12,
  parameter int WIDTH_CLAUSES    = 16,
  parameter int WIDTH_VAR_STATES = 19,
  parameter int WIDTH_LVL_STATES = 11,
  parameter int ADDR_WIDTH       = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [31:0]                 in_data,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [1:0]                  res_data,
  output logic                        err_o,
  output logic                        apply_ex_o,
  output logic                        ram_we_v_o,
  output logic                        ram_we_c_o,
  output logic                        ram_we_vs_o,
  output logic                        ram_we_ls_o,
  output logic [WIDTH_VAR-1:0]        ram_din_v_o,
  output logic [WIDTH_CLAUSES-1:0]    ram_din_c_o,
  output logic [WIDTH_VAR_STATES-1:0] ram_din_vs_o,
  output logic [WIDTH_LVL_STATES-1:0] ram_din_ls_o,
  output logic [ADDR_WIDTH-1:0]       ram_addr_v_o,
  output logic [ADDR_WIDTH-1:0]       ram_addr_c_o,
  output logic [ADDR_WIDTH-1:0]       ram_addr_vs_o,
  output logic [ADDR_WIDTH-1:0]       ram_addr_ls_o,
  output logic                        bin_info_en_o,
  output logic [WIDTH_VAR-1:0]        nv_all_o,
  output logic [WIDTH_CLAUSES-1:0]    nb_all_o,
  output logic                        start_o,
  input  logic                        done_i,
  input  logic                        global_sat_i,
  input  logic                        global_unsat_i,
  output logic [2:0]                  state_o
);

  localparam int DW_A = (WIDTH_VAR > WIDTH_CLAUSES) ? WIDTH_VAR : WIDTH_CLAUSES;
  localparam int DW_B = (WIDTH_VAR_STATES > WIDTH_LVL_STATES) ? WIDTH_VAR_STATES : WIDTH_LVL_STATES;
  localparam int DW   = (DW_A > DW_B) ? DW_A : DW_B;

  typedef enum logic [2:0] {
    S_IDLE, S_DATA, S_INFO0, S_INFO1, S_START, S_WAIT, S_RESULT
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              tgt_q, tgt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [15:0]             rem_q, rem_d;
  logic [3:0]              we_q, we_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [DW-1:0]           wr_data_q, wr_data_d;
  logic [WIDTH_VAR-1:0]    nv_q, nv_d;
  logic [WIDTH_CLAUSES-1:0] nb_q, nb_d;
  logic                    info_en_q, info_en_d;
  logic                    err_q, err_d;
  logic [1:0]              res_q, res_d;
  logic                    skip_q, skip_d;

  logic                    accept;
  logic [3:0]              op;
  logic [ADDR_WIDTH-1:0]   base;
  logic [15:0]             cnt;
  logic                    unused_in;

  // Both streams are valid/ready: a word transfers on a rising edge where valid
  // and ready are both high; the sender holds valid and data until then.
  assign in_ready  = state_q inside {S_IDLE, S_DATA, S_INFO0, S_INFO1};
  assign accept    = in_valid & in_ready;
  assign op        = in_data[31:28];
  assign base      = in_data[16+ADDR_WIDTH-1:16];
  assign cnt       = in_data[15:0];
  assign unused_in = ^in_data;

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    we_d      = '0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    nv_d      = nv_q;
    nb_d      = nb_q;
    info_en_d = 1'b0;
    err_d     = err_q;
    res_d     = res_q;
    skip_d    = skip_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op)
            4'd1, 4'd2, 4'd3, 4'd4: begin
              if (cnt != 16'd0) begin
                state_d = S_DATA;
                tgt_d   = 2'(op - 4'd1);
                addr_d  = base;
                rem_d   = cnt;
              end
            end
            4'd5:    state_d = S_INFO0;
            4'd6:    state_d = S_START;
            default: err_d   = 1'b1;
          endcase
        end
      end
      S_DATA: begin
        if (accept) begin
          we_d[tgt_q] = 1'b1;
          wr_addr_d   = addr_q;
          wr_data_d   = in_data[DW-1:0];
          addr_d      = addr_q + 1'b1;
          rem_d       = rem_q - 16'd1;
          if (rem_q == 16'd1) state_d = S_IDLE;
        end
      end
      S_INFO0: begin
        if (accept) begin
          nv_d    = in_data[WIDTH_VAR-1:0];
          state_d = S_INFO1;
        end
      end
      S_INFO1: begin
        if (accept) begin
          nb_d      = in_data[WIDTH_CLAUSES-1:0];
          info_en_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_START: begin
        state_d = S_WAIT;
        skip_d  = 1'b1;
      end
      S_WAIT: begin
        // done_i may still be high from the previous run on the first WAIT cycle.
        if (skip_q) begin
          skip_d = 1'b0;
        end else if (done_i) begin
          res_d   = {global_unsat_i, global_sat_i};
          state_d = S_RESULT;
        end
      end
      S_RESULT: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      tgt_q     <= '0;
      addr_q    <= '0;
      rem_q     <= '0;
      we_q      <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      nv_q      <= '0;
      nb_q      <= '0;
      info_en_q <= 1'b0;
      err_q     <= 1'b0;
      res_q     <= '0;
      skip_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      we_q      <= we_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      nv_q      <= nv_d;
      nb_q      <= nb_d;
      info_en_q <= info_en_d;
      err_q     <= err_d;
      res_q     <= res_d;
      skip_q    <= skip_d;
    end
  end

  assign apply_ex_o    = in_ready;
  assign start_o       = (state_q == S_START);
  assign res_valid     = (state_q == S_RESULT);
  assign res_data      = res_q;
  assign err_o         = err_q;
  assign ram_we_v_o    = we_q[0];
  assign ram_we_c_o    = we_q[1];
  assign ram_we_vs_o   = we_q[2];
  assign ram_we_ls_o   = we_q[3];
  assign ram_din_v_o   = wr_data_q[WIDTH_VAR-1:0];
  assign ram_din_c_o   = wr_data_q[WIDTH_CLAUSES-1:0];
  assign ram_din_vs_o  = wr_data_q[WIDTH_VAR_STATES-1:0];
  assign ram_din_ls_o  = wr_data_q[WIDTH_LVL_STATES-1:0];
  assign ram_addr_v_o  = wr_addr_q;
  assign ram_addr_c_o  = wr_addr_q;
  assign ram_addr_vs_o = wr_addr_q;
  assign ram_addr_ls_o = wr_addr_q;
  assign bin_info_en_o = info_en_q;
  assign nv_all_o      = nv_q;
  assign nb_all_o      = nb_q;
  assign state_o       = state_q;

endmodule
